// File: rtl/inst_issue_pkg.sv
// Shared constants, instruction-field layout and FSM encoding
// for the inst_issue sequencer.
package inst_issue_pkg;

    localparam int DEPTH      = 16;
    localparam int ADDR_W     = 4;
    localparam int CNT_W      = 8;
    localparam int PIPE_DELAY = 6;

    localparam int INST_W = 3 + CNT_W;
    localparam int CNT_LO = 0;
    localparam int CNT_HI = CNT_W - 1;
    localparam int OP_LO  = CNT_W;
    localparam int OP_HI  = CNT_W + 2;

    // Worst case: every entry at full count, none returned yet.
    localparam int OUT_W = $clog2(DEPTH * (2 ** CNT_W - 1) + 1);
    localparam int IGN_W = $clog2(PIPE_DELAY + 1);

    localparam logic [2:0] OP_LOAD   = 3'b000;
    localparam logic [2:0] OP_ADD    = 3'b001;
    localparam logic [2:0] OP_SUB    = 3'b010;
    localparam logic [2:0] OP_MUL    = 3'b100;
    localparam logic [2:0] OP_MULADD = 3'b101;
    localparam logic [2:0] OP_MULSUB = 3'b110;
    localparam logic [2:0] OP_MAX    = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        DRAIN
    } state_e;

    function automatic logic [2:0] ent_op(input logic [INST_W-1:0] e);
        return e[OP_HI:OP_LO];
    endfunction

    function automatic logic [CNT_W-1:0] ent_cnt(input logic [INST_W-1:0] e);
        return e[CNT_HI:CNT_LO];
    endfunction

endpackage

// File: rtl/inst_issue_if.sv
// Host/config and decoder-facing signals of the sequencer.
// master = host + decoder side, slave = sequencer.
interface inst_issue_if;
    import inst_issue_pkg::*;

    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [INST_W-1:0] prog_data;
    logic [ADDR_W:0]   prog_len;
    logic              start;
    logic              stall;
    logic              dout_v;
    logic              inst_v;
    logic [2:0]        opcode;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   pc;
    logic              err;

    modport master (
        output prog_we, prog_addr, prog_data, prog_len,
        output start, stall, dout_v,
        input  inst_v, opcode, busy, done, pc, err
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, prog_len,
        input  start, stall, dout_v,
        output inst_v, opcode, busy, done, pc, err
    );

endinterface

// File: rtl/inst_issue_mem.sv
// Program store: simple dual-port RAM, one write, one registered read.
module inst_mem
    import inst_issue_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [INST_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [INST_W-1:0] rdata
);

    logic [INST_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/inst_issue.sv
// Plays a {opcode, repeat} program to the PE control decoder,
// tracking returned results to signal completion.
module inst_issue
    import inst_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    inst_issue_if.slave bus
);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   pc_q, pc_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [CNT_W-1:0]  beats_q, beats_d;
    logic [2:0]        op_q, op_d;
    logic              inst_v_q, inst_v_d;
    logic [2:0]        opcode_q, opcode_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic [IGN_W-1:0]  ign_q, ign_d;
    logic              issue;
    logic              ret;
    logic [INST_W-1:0] rdata;

    // Read address follows next pc so the entry is ready in FETCH.
    inst_mem u_mem (
        .clk   (clk),
        .we    (bus.prog_we && state_q == IDLE),
        .waddr (bus.prog_addr),
        .wdata (bus.prog_data),
        .raddr (pc_d[ADDR_W-1:0]),
        .rdata (rdata)
    );

    // Results still in flight from before a reset are discarded.
    assign ret = bus.dout_v && (ign_q == '0);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        len_d    = len_q;
        beats_d  = beats_q;
        op_d     = op_q;
        inst_v_d = 1'b0;
        opcode_d = OP_LOAD;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        out_d    = out_q;
        ign_d    = (ign_q != '0) ? ign_q - 1'b1 : ign_q;
        issue    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.prog_len != '0) begin
                        len_d   = bus.prog_len;
                        pc_d    = '0;
                        busy_d  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                op_d = ent_op(rdata);
                if (ent_cnt(rdata) == '0) begin
                    pc_d = pc_q + 1'b1;
                    if (pc_d == len_q) begin
                        state_d = DRAIN;
                    end
                end else begin
                    beats_d = ent_cnt(rdata);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!bus.stall) begin
                    issue    = 1'b1;
                    inst_v_d = 1'b1;
                    opcode_d = op_q;
                    beats_d  = beats_q - 1'b1;
                    if (beats_q == 1) begin
                        pc_d    = pc_q + 1'b1;
                        state_d = (pc_d == len_q) ? DRAIN : FETCH;
                    end
                end
            end
            DRAIN: begin
                if (out_q == '0 || (out_q == 1 && ret)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase

        if (issue && !ret) begin
            out_d = out_q + 1'b1;
        end else if (!issue && ret) begin
            if (out_q == '0) begin
                err_d = 1'b1;
            end else begin
                out_d = out_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            len_q    <= '0;
            beats_q  <= '0;
            op_q     <= OP_LOAD;
            inst_v_q <= 1'b0;
            opcode_q <= OP_LOAD;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            out_q    <= '0;
            ign_q    <= IGN_W'(PIPE_DELAY);
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            len_q    <= len_d;
            beats_q  <= beats_d;
            op_q     <= op_d;
            inst_v_q <= inst_v_d;
            opcode_q <= opcode_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            out_q    <= out_d;
            ign_q    <= ign_d;
        end
    end

    assign bus.inst_v = inst_v_q;
    assign bus.opcode = opcode_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.pc     = pc_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_inst_issue.sv
// Self-checking bench for inst_issue: directed scenarios plus random
// programs compared against a slot-level timeline model.
module tb_inst_issue;
    import inst_issue_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic inj;
    logic [PIPE_DELAY-1:0] sr = '0;

    always #5 clk = ~clk;

    inst_issue_if bus();

    inst_issue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) sr <= {sr[PIPE_DELAY-2:0], bus.inst_v};
    assign bus.dout_v = sr[PIPE_DELAY-1] | inj;

    int total = 0;
    int bad   = 0;

    logic [2:0]       p_op  [DEPTH];
    logic [CNT_W-1:0] p_cnt [DEPTH];
    bit               s     [256];
    int               rv    [$];
    logic [2:0]       ro    [$];
    logic [2:0]       optab [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int j,
                       input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s slot=%0d observed=%0h expected=%0h",
                   tag, j, obs, exp);
        end
    endtask

    task automatic clear_stall();
        for (int k = 0; k < 256; k++) s[k] = 1'b0;
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            bus.prog_we   = 1'b1;
            bus.prog_addr = i[ADDR_W-1:0];
            bus.prog_data = {p_op[i], p_cnt[i]};
            tick();
        end
        bus.prog_we = 1'b0;
    endtask

    // Output timeline after the start edge: one lead slot, then per
    // entry one fetch slot followed by its beats (stalled slots idle).
    // Done follows the later of reaching drain and the last return.
    task automatic run_prog(input int n, input logic exp_err, input bit poke);
        int rem;
        int last;
        int dslot;
        int ev;
        logic [2:0] eo;
        load(n);
        rv.delete();
        ro.delete();
        rv.push_back(0);
        ro.push_back(OP_LOAD);
        for (int e = 0; e < n; e++) begin
            rv.push_back(0);
            ro.push_back(OP_LOAD);
            rem = int'(p_cnt[e]);
            while (rem > 0) begin
                if (s[rv.size()]) begin
                    rv.push_back(0);
                    ro.push_back(OP_LOAD);
                end else begin
                    rv.push_back(1);
                    ro.push_back(p_op[e]);
                    rem--;
                end
            end
        end
        last = -1;
        for (int j = 0; j < rv.size(); j++) if (rv[j] == 1) last = j;
        dslot = rv.size();
        if (last >= 0 && last + PIPE_DELAY + 1 > dslot)
            dslot = last + PIPE_DELAY + 1;
        bus.prog_len = n[ADDR_W:0];
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int j = 0; j <= dslot + 1; j++) begin
            ev = (j < rv.size()) ? rv[j] : 0;
            eo = (j < rv.size()) ? ro[j] : OP_LOAD;
            chk("inst_v", j, 32'(bus.inst_v), 32'(ev));
            chk("opcode", j, 32'(bus.opcode), 32'(eo));
            chk("done", j, 32'(bus.done), 32'(j == dslot));
            chk("busy", j, 32'(bus.busy), 32'(j < dslot));
            chk("err", j, 32'(bus.err), 32'(exp_err));
            if (j == dslot) chk("pc_end", j, 32'(bus.pc), 32'(n));
            bus.stall   = s[j+1];
            bus.prog_we = 1'b0;
            if (poke && j == 0) begin
                bus.prog_we   = 1'b1;
                bus.prog_addr = 4'd1;
                bus.prog_data = {OP_MAX, 8'd9};
            end
            tick();
        end
        bus.stall   = 1'b0;
        bus.prog_we = 1'b0;
    endtask

    task automatic set_add_mul();
        p_op[0] = OP_ADD; p_cnt[0] = 8'd3;
        p_op[1] = OP_MUL; p_cnt[1] = 8'd2;
    endtask

    initial begin
        optab[0] = OP_LOAD;   optab[1] = OP_ADD; optab[2] = OP_SUB;
        optab[3] = OP_MUL;    optab[4] = OP_MULADD;
        optab[5] = OP_MULSUB; optab[6] = OP_MAX;
        rst = 1'b1;
        inj = 1'b0;
        bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
        bus.prog_len = '0; bus.start = 1'b0; bus.stall = 1'b0;
        clear_stall();
        tick();
        tick();
        chk("rst_inst_v", 0, 32'(bus.inst_v), 0);
        chk("rst_opcode", 0, 32'(bus.opcode), 0);
        chk("rst_busy", 0, 32'(bus.busy), 0);
        chk("rst_done", 0, 32'(bus.done), 0);
        chk("rst_pc", 0, 32'(bus.pc), 0);
        chk("rst_err", 0, 32'(bus.err), 0);
        rst = 1'b0;
        repeat (8) tick();

        // Basic program; a write while busy must be dropped.
        set_add_mul();
        run_prog(2, 1'b0, 1'b1);

        // Two-cycle stall on the second ADD beat.
        s[3] = 1'b1;
        s[4] = 1'b1;
        run_prog(2, 1'b0, 1'b0);
        clear_stall();

        // Zero-count entry is skipped.
        p_op[0] = OP_SUB;    p_cnt[0] = 8'd1;
        p_op[1] = OP_MAX;    p_cnt[1] = 8'd0;
        p_op[2] = OP_MULADD; p_cnt[2] = 8'd1;
        run_prog(3, 1'b0, 1'b0);

        // Empty program.
        bus.prog_len = '0;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("len0_done", 0, 32'(bus.done), 1);
        chk("len0_busy", 0, 32'(bus.busy), 0);
        chk("len0_inst_v", 0, 32'(bus.inst_v), 0);
        tick();
        chk("len0_done_off", 1, 32'(bus.done), 0);
        chk("len0_busy_off", 1, 32'(bus.busy), 0);
        chk("len0_inst_v_off", 1, 32'(bus.inst_v), 0);

        // Spurious return while idle sets sticky err.
        inj = 1'b1;
        tick();
        inj = 1'b0;
        tick();
        chk("err_set", 0, 32'(bus.err), 1);
        set_add_mul();
        run_prog(2, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("err_clr", 0, 32'(bus.err), 0);
        repeat (8) tick();

        // Reset in the middle of issuing.
        set_add_mul();
        load(2);
        bus.prog_len = 5'd2;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        chk("mid_inst_v_pre", 3, 32'(bus.inst_v), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_inst_v", 0, 32'(bus.inst_v), 0);
        chk("mid_busy", 0, 32'(bus.busy), 0);
        chk("mid_pc", 0, 32'(bus.pc), 0);
        repeat (10) tick();
        chk("mid_err", 0, 32'(bus.err), 0);
        run_prog(2, 1'b0, 1'b0);

        // Random programs with random stalls.
        repeat (6) begin
            int n;
            n = int'($urandom_range(1, 6));
            for (int e = 0; e < n; e++) begin
                p_op[e]  = optab[$urandom_range(0, 6)];
                p_cnt[e] = CNT_W'($urandom_range(0, 4));
            end
            for (int k = 0; k < 256; k++) s[k] = ($urandom_range(0, 3) == 0);
            run_prog(n, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_issue.md
Name: inst_issue

Overview:
- Instruction sequencer that drives the inst_v/opcode pair consumed by the PE-array control decoder.
- Holds a small program of {opcode, repeat count} entries, loaded by the host.
- On start, plays the program out one opcode beat per cycle and honours stall.
- Counts results returned on the decoder's dout_v to detect completion; sits between the host/config interface and the control decoder.

Parameters:
DEPTH, 16, program entries
ADDR_W, 4, log2(DEPTH)
CNT_W, 8, repeat-count field width
PIPE_DELAY, 6, decoder inst_v→dout_v latency; sizes outstanding counter (max DEPTH*(2^CNT_W-1))

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
prog_we  in  1  program write strobe
prog_addr  in  ADDR_W  program write address
prog_data  in  3+CNT_W  {opcode[2:0], count[CNT_W-1:0]}
prog_len  in  ADDR_W+1  number of valid entries (0..DEPTH), sampled at start
start  in  1  begin program execution
stall  in  1  hold issue this cycle
dout_v  in  1  result-valid return from decoder
inst_v  out  1  instruction valid to decoder
opcode  out  3  opcode to decoder
busy  out  1  high from start acceptance until done
done  out  1  one-cycle completion pulse
pc  out  ADDR_W+1  current entry index
err  out  1  sticky: dout_v seen with zero outstanding

Behaviour:
- Reset: all of the following take these values: state IDLE, inst_v=0, opcode=3'b000, busy=0, done=0, pc=0, err=0, outstanding=0, beat counter=0. Program memory contents are not reset.
- Reset mid-run aborts immediately. Returning dout_v in the cycles after reset is ignored, and err is not set by it.
- Program memory: DEPTH x (3+CNT_W). Synchronous write when prog_we && state==IDLE; writes in any other state are dropped. Synchronous read, 1-cycle latency.
- inst_v and opcode are registered outputs. opcode=3'b000 (LOAD/no-op) whenever inst_v=0.
- FSM states: IDLE, FETCH, ISSUE, DRAIN.
- IDLE:
  - start=1, prog_len>0 → latch len, pc=0, busy=1, go to FETCH (mem read addr 0).
  - start=1, prog_len=0 → done=1 next cycle, stay IDLE, busy stays 0.
- FETCH: one cycle, the entry is captured. Then:
  - count==0 → entry skipped: pc+1; if pc+1==len go to DRAIN, else stay in FETCH.
  - count>0 → go to ISSUE, beats=count.
- ISSUE:
  - Each cycle with stall=0: inst_v=1, opcode=entry opcode, beats-1.
  - stall=1: inst_v=0, opcode=000, nothing advances.
  - After the last beat: pc+1; if pc+1==len go to DRAIN, else go to FETCH.
  - Exactly one bubble cycle separates consecutive entries.
- DRAIN: waits for outstanding==0. The cycle it is observed zero, done=1 (single cycle), busy=0, go to IDLE.
- Timing: start sampled at edge T → first inst_v=1 in the cycle after edge T+2.
- Outstanding counter:
  - +1 on each issued beat; -1 on dout_v; unchanged when both occur in the same cycle.
  - dout_v when outstanding==0 (with no simultaneous issue) → err=1 sticky until rst, counter stays 0.
- start while busy is ignored. stall outside ISSUE has no effect.
- pc reports the entry index being fetched or issued; it holds at len in DRAIN.

Decomposition:
- Shared parameters header: opcode constants (LOAD 000, ADD 001, SUB 010, MUL 100, MULADD 101, MULSUB 110, MAX 111), PIPE_DELAY, CNT_W, and the instruction-field slice positions.
- One sub-module, inst_mem: simple-dual-port synchronous RAM (1W/1R, registered read), so it can map to distributed RAM/BRAM.

Test Plan:
- The bench loops inst_v back to dout_v through a PIPE_DELAY=6 shift register unless noted.
- Program {ADD x3, MUL x2}, len=2, start at T → inst_v high T+2..T+4 with opcode 001; bubble at T+5 with opcode 000; inst_v high T+6..T+7 with opcode 100; done pulse one cycle after the last dout_v (T+13); busy low from then.
- Same program with stall=1 on the 2nd ADD beat for 2 cycles → inst_v low for those 2 cycles; total beats still 5; done delayed by 2 cycles.
- Entry count=0 between two entries {SUB x1, MAX x0, MULADD x1} → only opcodes 010 and 101 are issued; no MAX beat appears.
- prog_len=0 with start → done pulse next cycle; inst_v never asserts; busy stays 0.
- Extra dout_v pulse injected while idle → err=1 and held; a following normal run completes with err still 1; rst clears it.
- rst asserted mid-ISSUE → the cycle after the reset edge, inst_v=0, busy=0, pc=0; the delayed dout_v returns do not set err; a fresh start runs normally.
